// File: rtl/rr_arb_8.sv
// rtl/rr_arb_8.sv - eight-requester round-robin arbiter with registered owner index
//
// Shares one resource slot among eight requesters. The owner index is
// registered and the one-hot grant is a decode of that index gated by the
// valid flag. The owner keeps the grant while its request stays high.
// On release the grant passes directly to the next requester in round-robin
// order, with no idle cycle in between.
//
// Optional feature, enabled by defining RR_ARB_TIMEOUT_EN: a hold counter
// forces rotation after MAX_HOLD consecutive cycles, but only when another
// requester is waiting.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   en       in   1  arbiter enable; low drops any grant
//   req      in   8  request vector, bit i = requester i
//   gnt      out  8  one-hot grant, zero when gnt_vld is low
//   gnt_idx  out  3  registered index of the current owner
//   gnt_vld  out  1  grant active
module rr_arb_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] pick_idle;
  logic [3:0] pick_other;

  // Returns {found, index}. The search visits last+1 first and last itself
  // at the end, so the most recent owner always has the lowest priority.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!res[3] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign pick_idle  = rr_pick(req, ptr_q);
  // The current owner is masked out. This one search therefore serves both
  // a release (req[o]=0 already) and a timeout rotation (o must be skipped).
  assign pick_other = rr_pick(req & ~(8'b1 << idx_q), idx_q);

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD < 2);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (en && (req != 8'h00)) begin
          state_d = GRANT;
          idx_d   = pick_idle[2:0];
          ptr_d   = pick_idle[2:0];
        end
      end
      GRANT: begin
        if (!en) begin
          // Disable wins over release and timeout; index and pointer are kept.
          state_d = IDLE;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!req[idx_q]) begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (pick_other[3]) begin
            idx_d = pick_other[2:0];
            ptr_d = pick_other[2:0];
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          if ((cnt_q == HOLD_LAST) && pick_other[3]) begin
            idx_d = pick_other[2:0];
            ptr_d = pick_other[2:0];
            cnt_d = '0;
          end else if (cnt_q != HOLD_LAST) begin
            // Saturate at the limit so a lone owner keeps the grant.
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd7;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == GRANT);
  assign gnt     = gnt_vld ? (8'b1 << idx_q) : 8'h00;

endmodule

// File: doc/rr_arb_8.md
Name: rr_arb_8

Overview:
- Eight-requester round-robin arbiter that shares one resource slot among requesters.
- Registers a 3-bit owner index and drives a one-hot grant vector by 3-to-8 decoding of that index, gated by a valid flag.
- Sits in front of any shared resource whose users are selected by a decoder line.
- Owner holds the grant while its request stays high; an optional hold-timeout forces rotation.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while others wait. Range >= 2. Used only when RR_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  arbiter enable; low forces the grant off
- req  input  8  request vector, bit i = requester i
- gnt  output  8  one-hot grant; equals decode(gnt_idx) when gnt_vld=1, else 8'h00
- gnt_idx  output  3  registered index of the current owner
- gnt_vld  output  1  high while a grant is active

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - gnt=8'h00, gnt_idx=3'd0, gnt_vld=0.
  - State IDLE, last-owner pointer ptr=3'd7, so requester 0 has first priority. Hold counter=0.
- Arbitration function: winner = first i with req[i]=1, searching ptr+1, ptr+2, ... modulo 8. The search wraps from 7 to 0. The requester at ptr is checked last.
- State IDLE:
  - If en=1 and req!=0: on the next edge, gnt_idx=winner, gnt_vld=1, ptr=winner, state=GRANT.
  - Latency from req to gnt is 1 cycle. Otherwise, remain in IDLE.
- State GRANT, with owner o=gnt_idx:
  - en=0: next edge gnt_vld=0, state=IDLE. ptr and gnt_idx are retained.
  - en=1, req[o]=1: hold the grant with no change.
  - en=1, req[o]=0, other requests pending: next edge, grant the winner searched from o+1. This is a back-to-back handover with no idle bubble. Update ptr; counter=0.
  - en=1, req[o]=0, no requests: next edge gnt_vld=0, state=IDLE.
- Simultaneous events: en=0 takes precedence over release and over timeout. A new request arriving in the same cycle as a release participates in that arbitration.
- gnt is purely combinational from the registered gnt_idx and gnt_vld. It is glitch-free relative to clk and never has more than one bit set.
- A request deasserted before it is granted is simply lost. No request is latched.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width clog2(MAX_HOLD) increments every GRANT cycle.
  - When counter==MAX_HOLD-1, en=1, and any req[j]=1 with j!=o: next edge, grant the winner searched from o+1 while excluding o. Counter=0, ptr updated.
  - If no other requester is pending, the owner keeps the grant and the counter holds at MAX_HOLD-1.
  - The counter clears on every new grant and on IDLE.
- Not defined: no counter logic is present. An owner holds the grant indefinitely while its req stays high.

Test Plan:
- Reset then single request: rst_n=0 -> gnt=8'h00, gnt_vld=0. Release, en=1, req=8'h01 -> after 1 edge gnt=8'h01, gnt_idx=0.
- Rotation: from reset, req=8'h81 -> gnt_idx=0. Drop bit0 -> next edge gnt_idx=7 with no bubble. Reassert bit0, drop bit7 -> next edge gnt_idx=0.
- Fairness and wrap: owner 6 releases with req=8'h41 (req[6] reasserted the same cycle) -> next grant is idx 0, not 6. Full rotation with req=8'hFF and each owner releasing after 1 cycle yields idx sequence 0,1,...,7,0.
- Enable drop: en=0 during a grant to idx 3 -> next edge gnt=8'h00, gnt_vld=0. en=1 with req=8'h18 -> grant idx 4.
- Timeout (macro defined, MAX_HOLD=4): req=8'h03 held -> idx0 for 4 cycles, idx1 for 4 cycles, then alternating. Without the macro, idx0 holds for 100+ cycles.
- Asynchronous reset mid-grant: assert rst_n=0 between edges -> gnt=8'h00 immediately. After release with req=8'h80, grant goes to idx 7 on the first edge with en=1.
